// File: rtl/debug_sba_master.sv
// Debug system bus access master: validates one sbaddress/sbdata request, runs a single req/ack
// cycle on the debug port of the data-memory arbiter. Optional bus timeout under SBA_TIMEOUT_EN.
module debug_sba_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] sb_iAddr,
    input  logic [31:0] sb_iData,
    input  logic        sb_iRead,
    input  logic        sb_iWrite,
    input  logic [2:0]  sb_iWidth,
    output logic        sb_oBusy,
    output logic [2:0]  sb_oErr,
    output logic [31:0] sb_oData,
    output logic        mem_oReq,
    output logic        mem_oWe,
    output logic [31:0] mem_oAddr,
    output logic [3:0]  mem_oBE,
    output logic [31:0] mem_oWData,
    input  logic        mem_iAck,
    input  logic        mem_iErr,
    input  logic [31:0] mem_iRData
);

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrTimeout = 3'd1;
    localparam logic [2:0] ErrBadAddr = 3'd2;
    localparam logic [2:0] ErrAlign   = 3'd3;
    localparam logic [2:0] ErrSize    = 3'd4;
    localparam logic [2:0] ErrOther   = 3'd7;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      stateQ, stateD;
    logic [1:0]  addrLoQ, addrLoD;
    logic [1:0]  widthQ, widthD;
    logic        memReqQ, memReqD;
    logic        memWeQ, memWeD;
    logic [31:0] memAddrQ, memAddrD;
    logic [3:0]  memBEQ, memBED;
    logic [31:0] memWDataQ, memWDataD;
    logic [2:0]  errQ, errD;
    logic [31:0] rdataQ, rdataD;
`ifdef SBA_TIMEOUT_EN
    logic [TO_W-1:0] cntQ, cntD;
`endif

    logic        misalign;
    logic [3:0]  beNew;
    logic [31:0] wdataNew;
    logic [31:0] rdShift;
    logic [31:0] rdMasked;

    always_comb begin
        misalign = (sb_iWidth == 3'd1 && sb_iAddr[0]) ||
                   (sb_iWidth == 3'd2 && sb_iAddr[1:0] != 2'b00);
        unique case (sb_iWidth[1:0])
            2'd0:    beNew = 4'b0001 << sb_iAddr[1:0];
            2'd1:    beNew = 4'b0011 << sb_iAddr[1:0];
            default: beNew = 4'b1111;
        endcase
        unique case (sb_iWidth[1:0])
            2'd0:    wdataNew = {4{sb_iData[7:0]}};
            2'd1:    wdataNew = {2{sb_iData[15:0]}};
            default: wdataNew = sb_iData;
        endcase
        rdShift = mem_iRData >> {addrLoQ, 3'b000};
        unique case (widthQ)
            2'd0:    rdMasked = {24'd0, rdShift[7:0]};
            2'd1:    rdMasked = {16'd0, rdShift[15:0]};
            default: rdMasked = rdShift;
        endcase
    end

    always_comb begin
        stateD    = stateQ;
        addrLoD   = addrLoQ;
        widthD    = widthQ;
        memReqD   = memReqQ;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memBED    = memBEQ;
        memWDataD = memWDataQ;
        errD      = errQ;
        rdataD    = rdataQ;
`ifdef SBA_TIMEOUT_EN
        cntD      = cntQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (sb_iRead || sb_iWrite) begin
                    errD    = ErrNone;
                    addrLoD = sb_iAddr[1:0];
                    widthD  = sb_iWidth[1:0];
                    if (sb_iRead && sb_iWrite) begin
                        errD   = ErrOther;
                        stateD = StResp;
                    end else if (sb_iWidth > 3'd2) begin
                        errD   = ErrSize;
                        stateD = StResp;
                    end else if (misalign) begin
                        errD   = ErrAlign;
                        stateD = StResp;
                    end else begin
                        stateD    = StReq;
                        memWeD    = sb_iWrite;
                        memAddrD  = {sb_iAddr[31:2], 2'b00};
                        memBED    = beNew;
                        memWDataD = wdataNew;
`ifdef SBA_TIMEOUT_EN
                        cntD      = '0;
`endif
                    end
                end
            end
            StReq: begin
                // Request goes out one cycle after acceptance; acks before that are ignored.
                if (!memReqQ) begin
                    memReqD = 1'b1;
                end else if (mem_iAck) begin
                    memReqD = 1'b0;
                    stateD  = StResp;
                    if (mem_iErr) begin
                        errD = ErrBadAddr;
                    end else if (!memWeQ) begin
                        rdataD = rdMasked;
                    end
                end
`ifdef SBA_TIMEOUT_EN
                else if (cntQ == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    memReqD = 1'b0;
                    errD    = ErrTimeout;
                    stateD  = StResp;
                end else begin
                    cntD = cntQ + 1'b1;
                end
`endif
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ    <= StIdle;
            addrLoQ   <= 2'd0;
            widthQ    <= 2'd0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= 32'd0;
            memBEQ    <= 4'd0;
            memWDataQ <= 32'd0;
            errQ      <= ErrNone;
            rdataQ    <= 32'd0;
`ifdef SBA_TIMEOUT_EN
            cntQ      <= '0;
`endif
        end else begin
            stateQ    <= stateD;
            addrLoQ   <= addrLoD;
            widthQ    <= widthD;
            memReqQ   <= memReqD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memBEQ    <= memBED;
            memWDataQ <= memWDataD;
            errQ      <= errD;
            rdataQ    <= rdataD;
`ifdef SBA_TIMEOUT_EN
            cntQ      <= cntD;
`endif
        end
    end

    assign sb_oBusy   = (stateQ != StIdle);
    assign sb_oErr    = errQ;
    assign sb_oData   = rdataQ;
    assign mem_oReq   = memReqQ;
    assign mem_oWe    = memWeQ;
    assign mem_oAddr  = memAddrQ;
    assign mem_oBE    = memBEQ;
    assign mem_oWData = memWDataQ;

endmodule

// File: tb/tb_debug_sba_master.sv
// Directed bench for debug_sba_master; define SBA_TIMEOUT_EN to also exercise the bus timeout.
module tb_debug_sba_master;

`ifdef SBA_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 256;
`endif

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] sb_iAddr = '0;
    logic [31:0] sb_iData = '0;
    logic        sb_iRead = 1'b0;
    logic        sb_iWrite = 1'b0;
    logic [2:0]  sb_iWidth = '0;
    logic        sb_oBusy;
    logic [2:0]  sb_oErr;
    logic [31:0] sb_oData;
    logic        mem_oReq;
    logic        mem_oWe;
    logic [31:0] mem_oAddr;
    logic [3:0]  mem_oBE;
    logic [31:0] mem_oWData;
    logic        mem_iAck = 1'b0;
    logic        mem_iErr = 1'b0;
    logic [31:0] mem_iRData = '0;

    int errors = 0;
    int checks = 0;

    int          busyCyc, reqCyc;
    logic        sawReq, oWe;
    logic [31:0] oAddr, oWData;
    logic [3:0]  oBE;

    debug_sba_master #(.TIMEOUT_CYCLES(TO)) dut (
        .iClk(iClk), .iRst(iRst),
        .sb_iAddr(sb_iAddr), .sb_iData(sb_iData), .sb_iRead(sb_iRead), .sb_iWrite(sb_iWrite),
        .sb_iWidth(sb_iWidth), .sb_oBusy(sb_oBusy), .sb_oErr(sb_oErr), .sb_oData(sb_oData),
        .mem_oReq(mem_oReq), .mem_oWe(mem_oWe), .mem_oAddr(mem_oAddr), .mem_oBE(mem_oBE),
        .mem_oWData(mem_oWData), .mem_iAck(mem_iAck), .mem_iErr(mem_iErr),
        .mem_iRData(mem_iRData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; ack arrives ackDelay cycles after mem_oReq rises (negative = never).
    task automatic doReq(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] width, input int ackDelay,
                         input logic [31:0] rdata, input logic berr);
        int waited;
        @(negedge iClk);
        sb_iRead = rd; sb_iWrite = wr; sb_iAddr = addr; sb_iData = data; sb_iWidth = width;
        @(negedge iClk);
        sb_iRead = 1'b0; sb_iWrite = 1'b0;
        busyCyc = 0; reqCyc = 0; sawReq = 1'b0; waited = 0;
        oWe = 1'b0; oAddr = '0; oBE = '0; oWData = '0;
        for (int i = 0; i < 60; i++) begin
            if (!sb_oBusy) break;
            busyCyc++;
            if (mem_oReq) begin
                if (!sawReq) begin
                    oWe = mem_oWe; oAddr = mem_oAddr; oBE = mem_oBE; oWData = mem_oWData;
                end
                sawReq = 1'b1;
                reqCyc++;
                if (waited == ackDelay) begin
                    mem_iAck = 1'b1; mem_iErr = berr; mem_iRData = rdata;
                end
                waited++;
            end
            @(negedge iClk);
            mem_iAck = 1'b0; mem_iErr = 1'b0;
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(sb_oBusy), 32'd0);
        chk("rst_err", 32'(sb_oErr), 32'd0);
        chk("rst_data", sb_oData, 32'd0);
        chk("rst_req", 32'(mem_oReq), 32'd0);
        chk("rst_we_be", {27'd0, mem_oWe, mem_oBE}, 32'd0);
        chk("rst_addr_wdata", mem_oAddr | mem_oWData, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;

        doReq(1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 3'd2, 0, 32'h0, 1'b0);
        chk("ww_busy", busyCyc, 3);
        chk("ww_addr", oAddr, 32'h1000);
        chk("ww_be", 32'(oBE), 32'hF);
        chk("ww_wdata", oWData, 32'hDEADBEEF);
        chk("ww_we", 32'(oWe), 32'd1);
        chk("ww_err", 32'(sb_oErr), 32'd0);

        doReq(1'b1, 1'b0, 32'h1003, 32'h0, 3'd0, 0, 32'hAABBCCDD, 1'b0);
        chk("br_addr", oAddr, 32'h1000);
        chk("br_be", 32'(oBE), 32'h8);
        chk("br_we", 32'(oWe), 32'd0);
        chk("br_data", sb_oData, 32'h000000AA);
        chk("br_err", 32'(sb_oErr), 32'd0);

        doReq(1'b0, 1'b1, 32'h2002, 32'h00001234, 3'd1, 0, 32'hFFFFFFFF, 1'b0);
        chk("hw_be", 32'(oBE), 32'hC);
        chk("hw_wdata", oWData, 32'h12341234);
        chk("hw_data_kept", sb_oData, 32'h000000AA);

        doReq(1'b1, 1'b0, 32'h0002, 32'h0, 3'd1, 2, 32'h11223344, 1'b0);
        chk("hr_busy", busyCyc, 5);
        chk("hr_data", sb_oData, 32'h00001122);

        doReq(1'b0, 1'b1, 32'h0005, 32'hFFFFFF5A, 3'd0, 1, 32'h0, 1'b0);
        chk("bw_be", 32'(oBE), 32'h2);
        chk("bw_wdata", oWData, 32'h5A5A5A5A);

        doReq(1'b1, 1'b0, 32'h2001, 32'h0, 3'd2, 0, 32'h0, 1'b0);
        chk("mis_req", 32'(sawReq), 32'd0);
        chk("mis_busy", busyCyc, 1);
        chk("mis_err", 32'(sb_oErr), 32'd3);
        chk("mis_data_kept", sb_oData, 32'h00001122);

        doReq(1'b1, 1'b0, 32'h0003, 32'h0, 3'd1, 0, 32'h0, 1'b0);
        chk("mish_err", 32'(sb_oErr), 32'd3);

        doReq(1'b1, 1'b0, 32'h0000, 32'h0, 3'd3, 0, 32'h0, 1'b0);
        chk("w3_req", 32'(sawReq), 32'd0);
        chk("w3_busy", busyCyc, 1);
        chk("w3_err", 32'(sb_oErr), 32'd4);

        doReq(1'b1, 1'b0, 32'h0000, 32'h0, 3'd4, 0, 32'h0, 1'b0);
        chk("w4_err", 32'(sb_oErr), 32'd4);

        doReq(1'b1, 1'b1, 32'h0000, 32'h0, 3'd2, 0, 32'h0, 1'b0);
        chk("rw_req", 32'(sawReq), 32'd0);
        chk("rw_err", 32'(sb_oErr), 32'd7);

        doReq(1'b1, 1'b0, 32'h0004, 32'h0, 3'd2, 0, 32'hFFFFFFFF, 1'b1);
        chk("be_err", 32'(sb_oErr), 32'd2);
        chk("be_data_kept", sb_oData, 32'h00001122);

        doReq(1'b1, 1'b0, 32'h0008, 32'h0, 3'd2, 0, 32'hCAFEF00D, 1'b0);
        chk("wr_err_clr", 32'(sb_oErr), 32'd0);
        chk("wr_data", sb_oData, 32'hCAFEF00D);

        // Stray ack while idle must not start or complete anything.
        @(negedge iClk);
        mem_iAck = 1'b1; mem_iRData = 32'h12345678;
        @(negedge iClk);
        mem_iAck = 1'b0;
        chk("idle_ack_busy", 32'(sb_oBusy), 32'd0);
        chk("idle_ack_data", sb_oData, 32'hCAFEF00D);

`ifdef SBA_TIMEOUT_EN
        doReq(1'b1, 1'b0, 32'h0010, 32'h0, 3'd2, -1, 32'h0, 1'b0);
        chk("to_req_cycles", reqCyc, 8);
        chk("to_busy", busyCyc, 10);
        chk("to_err", 32'(sb_oErr), 32'd1);
`endif

        // Reset while the request is outstanding.
        @(negedge iClk);
        sb_iRead = 1'b1; sb_iAddr = 32'h0020; sb_iWidth = 3'd2;
        @(negedge iClk);
        sb_iRead = 1'b0;
        @(negedge iClk);
        chk("ar_req_up", 32'(mem_oReq), 32'd1);
        #2 iRst = 1'b1;
        #1;
        chk("ar_req", 32'(mem_oReq), 32'd0);
        chk("ar_busy", 32'(sb_oBusy), 32'd0);
        chk("ar_err", 32'(sb_oErr), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_sba_master.md
Name: debug_sba_master

Overview:
- Debug System Bus Access engine. It sits directly downstream of the debug CSR block.
- Accepts a single sbaddress/sbdata read or write request (address, data, width) and validates size and alignment.
- Runs one req/ack transaction on the core data-memory arbiter's debug port, with byte-lane steering.
- Returns read data and a debug::sberr_e status, with busy asserted while the transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 256, cycles mem_oReq may remain unacknowledged before abort (used only with the optional feature).
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset, asynchronous, active-high
- sb_iAddr  in  32  byte address from debug CSRs
- sb_iData  in  32  write data, LSB-justified
- sb_iRead  in  1  read request pulse
- sb_iWrite  in  1  write request pulse
- sb_iWidth  in  3  debug::sbaccess_e access size
- sb_oBusy  out  1  transaction in flight
- sb_oErr  out  3  debug::sberr_e result of the last transaction
- sb_oData  out  32  read data, zero-extended, LSB-justified
- mem_oReq  out  1  bus request, held until ack
- mem_oWe  out  1  1 = write
- mem_oAddr  out  32  word-aligned address ({sb_iAddr[31:2],2'b00})
- mem_oBE  out  4  byte enables
- mem_oWData  out  32  lane-replicated write data
- mem_iAck  in  1  one-cycle completion strobe
- mem_iErr  in  1  bus error, valid with mem_iAck
- mem_iRData  in  32  read word, valid with mem_iAck

Behaviour:
- States: IDLE, REQ, RESP. Reset (asynchronous, immediate) forces:
  - state IDLE
  - all outputs 0 (sb_oErr = 0, none)
  - counter 0
- An abort mid-transfer drops mem_oReq the same instant; no completion is reported.
- IDLE accepts a request when sb_iRead | sb_iWrite.
  - Address, data, width and direction are latched at the accepting edge.
  - sb_oErr is cleared to 0 at the same edge.
  - Requests arriving while busy are ignored.
- Validation at acceptance, with no bus cycle issued on failure:
  - sb_iRead & sb_iWrite -> err 7 (other).
  - Width 3 or 4 -> err 4 (size).
  - Half with addr[0]=1, or word with addr[1:0]!=0 -> err 3 (alignment).
  - On a failure, sb_oBusy pulses high for exactly one cycle, then state returns to IDLE.
- A valid request enters REQ.
  - mem_oReq, mem_oWe, mem_oAddr, mem_oBE and mem_oWData are registered and stable from the cycle after acceptance until the ack cycle inclusive.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Write data: byte data is replicated x4 and half data x2.
- REQ exits on mem_iAck.
  - mem_oReq drops the next cycle; state goes to RESP.
  - On a read, sb_oData = mem_iRData >> (8*addr[1:0]), masked to the access width.
  - mem_iErr=1 -> err 2 (badaddr); sb_oData is not updated.
  - On a write, sb_oData is unchanged.
- RESP lasts one cycle with sb_oBusy=1, then IDLE with busy=0.
  - sb_oErr and sb_oData are valid when busy falls and hold until the next accept.
- Latency: accept at edge N; mem_oReq high from N+1.
  - With an ack at cycle N+1+k, busy falls at N+3+k.
  - The minimum busy window is 3 cycles.
- mem_iAck outside REQ is ignored.

Optional Feature:
- Macro SBA_TIMEOUT_EN.
- Defined: the counter increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mem_oReq drops, err 1 (timeout), go to RESP.
  - An ack in the same cycle as expiry wins over the timeout.
- Not defined: no counter is built, and REQ waits indefinitely for mem_iAck.

Test Plan:
- Word write: addr 0x1000, data 0xDEADBEEF, width 2 -> mem_oBE=4'hF, mem_oWData=0xDEADBEEF, mem_oWe=1; err 0; busy 3 cycles with an immediate ack.
- Byte read: addr 0x1003, mem_iRData 0xAABBCCDD -> mem_oAddr 0x1000, mem_oBE 4'b1000, sb_oData 0x000000AA, err 0.
- Half write: addr 0x2002, data 0x1234 -> mem_oBE 4'b1100, mem_oWData 0x12341234.
- Misaligned word read at 0x2001 -> no mem_oReq, err 3, busy high one cycle.
- Width 3 read -> no mem_oReq, err 4.
- Bus error and reset:
  - A read acked with mem_iErr=1 -> err 2, sb_oData unchanged.
  - With SBA_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> mem_oReq drops after 8 cycles, err 1.
  - iRst asserted during REQ -> mem_oReq=0 immediately, err 0.
